// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding encodings,
// FSM states, scoreboard slot indices and the forwarding-select helper.
package hazard_controller_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned SB_SLOTS = 3;
  localparam int unsigned SLOT_EXE = 0;
  localparam int unsigned SLOT_MEM = 1;
  localparam int unsigned SLOT_WB  = 2;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // MEM is the younger producer, so it wins when both stages match.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot (EXE/MEM/WB) in-flight writeback tracker with hazard and forwarding matches.
// Behaviour depends on FORWARDING_EN (load-use only hazards plus forwarding selects).
module hazard_scoreboard
  import hazard_controller_pkg::*;
#(
  parameter int unsigned REG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             load_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_dest,
  output logic             hz_c,
  output logic [1:0]       fwd_sel_a_c,
  output logic [1:0]       fwd_sel_b_c
);

  // Bit/row index 0 = EXE, 1 = MEM, 2 = WB.
  logic [SB_SLOTS-1:0]            valid;
  logic [SB_SLOTS-1:0]            wb_en;
  logic [SB_SLOTS-1:0]            mem_read;
  logic [SB_SLOTS-1:0]            two_src;
  logic [SB_SLOTS-1:0][REG_W-1:0] dest;
  logic [SB_SLOTS-1:0][REG_W-1:0] src1;
  logic [SB_SLOTS-1:0][REG_W-1:0] src2;

  logic [SB_SLOTS-1:0] hit_a;
  logic [SB_SLOTS-1:0] hit_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (advance) begin
      valid <= {valid[SLOT_MEM], valid[SLOT_EXE], load_en};
    end
  end

  // Payload fields are qualified by valid and need no reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      wb_en    <= {wb_en[1:0], id_wb_en};
      mem_read <= {mem_read[1:0], id_mem_read};
      two_src  <= {two_src[1:0], id_two_src};
      dest     <= {dest[1:0], id_dest};
      src1     <= {src1[1:0], id_src1};
      src2     <= {src2[1:0], id_src2};
    end
  end

  // Per-slot match of the ID instruction's used sources against in-flight writebacks.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int s = 0; s < int'(SB_SLOTS); s++) begin
      hit_a[s] = valid[s] & wb_en[s] & (dest[s] == id_src1);
      hit_b[s] = valid[s] & wb_en[s] & id_two_src & (dest[s] == id_src2);
    end
  end

`ifdef FORWARDING_EN
  logic fa_mem, fa_wb, fb_mem, fb_wb;

  assign hz_c = id_valid & mem_read[SLOT_EXE] & (hit_a[SLOT_EXE] | hit_b[SLOT_EXE]);

  assign fa_mem = valid[SLOT_EXE] & valid[SLOT_MEM] & wb_en[SLOT_MEM] &
                  (dest[SLOT_MEM] == src1[SLOT_EXE]);
  assign fa_wb  = valid[SLOT_EXE] & valid[SLOT_WB] & wb_en[SLOT_WB] &
                  (dest[SLOT_WB] == src1[SLOT_EXE]);
  assign fb_mem = valid[SLOT_EXE] & two_src[SLOT_EXE] & valid[SLOT_MEM] & wb_en[SLOT_MEM] &
                  (dest[SLOT_MEM] == src2[SLOT_EXE]);
  assign fb_wb  = valid[SLOT_EXE] & two_src[SLOT_EXE] & valid[SLOT_WB] & wb_en[SLOT_WB] &
                  (dest[SLOT_WB] == src2[SLOT_EXE]);

  assign fwd_sel_a_c = fwd_pick(fa_mem, fa_wb);
  assign fwd_sel_b_c = fwd_pick(fb_mem, fb_wb);
`else
  assign hz_c = id_valid & (hit_a[SLOT_EXE] | hit_b[SLOT_EXE] |
                            hit_a[SLOT_MEM] | hit_b[SLOT_MEM]);
  assign fwd_sel_a_c = FWD_REG;
  assign fwd_sel_b_c = FWD_REG;
`endif

  // Not every slot field is consumed in every build.
  logic unused_sb;
  assign unused_sb = ^{valid, wb_en, mem_read, two_src, dest, src1, src2};

endmodule

// File: rtl/hazard_controller.sv
// IF/ID/EXE/MEM/WB hazard controller: memory-wait hold, branch flush, data-hazard stall.
// Define FORWARDING_EN to enable operand forwarding (load-use stalls only).
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_dest,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             freeze,
  output logic             id_bubble,
  output logic             flush,
  output logic             pipe_hold,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e           state_q, state_d;
  logic             br_pend_q, br_pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hz_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
    end
  end

  // A cycle with mem_ready=1 is a run cycle even while leaving MEM_WAIT;
  // that exit cycle is where a branch latched during the wait gets flushed.
  always_comb begin
    state_d   = state_q;
    br_pend_d = br_pend_q;
    freeze    = 1'b0;
    id_bubble = 1'b0;
    flush     = 1'b0;
    pipe_hold = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!mem_ready) begin
          state_d   = ST_MEM_WAIT;
          br_pend_d = branch_taken;
          pipe_hold = 1'b1;
          freeze    = 1'b1;
        end else if (branch_taken) begin
          flush = 1'b1;
        end else if (hz_c) begin
          freeze    = 1'b1;
          id_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          br_pend_d = br_pend_q | branch_taken;
          pipe_hold = 1'b1;
          freeze    = 1'b1;
        end else begin
          state_d   = ST_RUN;
          br_pend_d = 1'b0;
          if (branch_taken || br_pend_q) begin
            flush = 1'b1;
          end else if (hz_c) begin
            freeze    = 1'b1;
            id_bubble = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Saturating count of frozen cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (freeze && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = cnt_q;

  hazard_scoreboard #(.REG_W(REG_W)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .advance     (~pipe_hold),
    .load_en     (id_valid & ~id_bubble & ~flush),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_wb_en    (id_wb_en),
    .id_mem_read (id_mem_read),
    .id_dest     (id_dest),
    .hz_c        (hz_c),
    .fwd_sel_a_c (fwd_sel_a),
    .fwd_sel_b_c (fwd_sel_b)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random traffic
// checked every cycle against a pipeline-level reference model.
module tb_hazard_controller;

  localparam int unsigned REG_W = 4;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic             id_mem_read;
  logic [REG_W-1:0] id_dest;
  logic             branch_taken;
  logic             mem_ready;
  logic             freeze;
  logic             id_bubble;
  logic             flush;
  logic             pipe_hold;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_wb_en     (id_wb_en),
    .id_mem_read  (id_mem_read),
    .id_dest      (id_dest),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .freeze       (freeze),
    .id_bubble    (id_bubble),
    .flush        (flush),
    .pipe_hold    (pipe_hold),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall_cycles (stall_cycles)
  );

  // Reference model: the three instructions in flight past ID, youngest first.
  typedef struct {
    bit       v;
    bit       wb;
    bit       ld;
    bit       two;
    bit [3:0] d;
    bit [3:0] s1;
    bit [3:0] s2;
  } instr_t;

  instr_t      inflight[3];
  bit          m_pend;
  int unsigned m_stalls;
  bit          e_freeze, e_bubble, e_flush, e_hold;
  bit [1:0]    e_fa, e_fb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit reads_result_of(input instr_t p);
    return p.v && p.wb && id_valid &&
           (p.d == id_src1 || (id_two_src && p.d == id_src2));
  endfunction

  function automatic bit [1:0] fwd_for(input bit [3:0] src, input bit used);
    if (!inflight[0].v || !used) return 2'd0;
    if (inflight[1].v && inflight[1].wb && inflight[1].d == src) return 2'd1;
    if (inflight[2].v && inflight[2].wb && inflight[2].d == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_comb();
    bit hz;
`ifdef FORWARDING_EN
    hz   = inflight[0].ld && reads_result_of(inflight[0]);
    e_fa = fwd_for(inflight[0].s1, 1'b1);
    e_fb = fwd_for(inflight[0].s2, inflight[0].two);
`else
    hz   = reads_result_of(inflight[0]) || reads_result_of(inflight[1]);
    e_fa = 2'd0;
    e_fb = 2'd0;
`endif
    e_hold   = !mem_ready;
    e_freeze = 1'b0;
    e_bubble = 1'b0;
    e_flush  = 1'b0;
    if (!mem_ready)                 e_freeze = 1'b1;
    else if (branch_taken || m_pend) e_flush = 1'b1;
    else if (hz) begin
      e_freeze = 1'b1;
      e_bubble = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) inflight[i] = '{default: 0};
    m_pend   = 1'b0;
    m_stalls = 0;
  endtask

  task automatic model_seq();
    instr_t n;
    if (rst) begin
      model_reset();
      return;
    end
    if (e_freeze && m_stalls < CNT_MAX) m_stalls++;
    if (!mem_ready) m_pend = m_pend | branch_taken;
    else            m_pend = 1'b0;
    if (!e_hold) begin
      n = '{default: 0};
      if (id_valid && !e_bubble && !e_flush)
        n = '{v: 1'b1, wb: id_wb_en, ld: id_mem_read, two: id_two_src,
              d: id_dest, s1: id_src1, s2: id_src2};
      inflight[2] = inflight[1];
      inflight[1] = inflight[0];
      inflight[0] = n;
    end
  endtask

  // Inputs are driven 1 time unit after posedge; outputs sampled 4 units after.
  task automatic step();
    model_comb();
    #3;
    chk("freeze", 16'(freeze), 16'(e_freeze));
    chk("id_bubble", 16'(id_bubble), 16'(e_bubble));
    chk("flush", 16'(flush), 16'(e_flush));
    chk("pipe_hold", 16'(pipe_hold), 16'(e_hold));
    chk("fwd_sel_a", 16'(fwd_sel_a), 16'(e_fa));
    chk("fwd_sel_b", 16'(fwd_sel_b), 16'(e_fb));
    chk("stall_cycles", 16'(stall_cycles), 16'(m_stalls));
    @(posedge clk);
    model_seq();
    #1;
    cyc++;
  endtask

  task automatic set_id(input bit v, input bit [3:0] s1, input bit [3:0] s2, input bit two,
                        input bit wb, input bit ld, input bit [3:0] d);
    id_valid    = v;
    id_src1     = s1;
    id_src2     = s2;
    id_two_src  = two;
    id_wb_en    = wb;
    id_mem_read = ld;
    id_dest     = d;
  endtask

  initial begin
    rst          = 1'b1;
    branch_taken = 1'b0;
    mem_ready    = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;

    // Reset state with idle inputs.
    #3;
    chk("rst_freeze", 16'(freeze), 16'd0);
    chk("rst_flush", 16'(flush), 16'd0);
    chk("rst_hold", 16'(pipe_hold), 16'd0);
    chk("rst_stalls", 16'(stall_cycles), 16'd0);
    #1;
    step();

    // Writer of R1 followed by a reader of R1.
    set_id(1, 4'd2, 4'd0, 0, 1, 0, 4'd1); step();
    set_id(1, 4'd1, 4'd0, 0, 1, 0, 4'd3);
    repeat (3) step();
    set_id(0, 0, 0, 0, 0, 0, 0); step();

    // Load-use on R2 with a two-source consumer.
    set_id(1, 4'd4, 4'd0, 0, 1, 1, 4'd2); step();
    set_id(1, 4'd5, 4'd2, 1, 1, 0, 4'd6);
    repeat (3) step();
    set_id(0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // Taken branch flushes the R5 writer; a later R5 reader must not stall.
    set_id(1, 4'd0, 4'd0, 0, 1, 0, 4'd5); branch_taken = 1'b1; step();
    branch_taken = 1'b0;
    set_id(1, 4'd5, 4'd0, 0, 1, 0, 4'd7); step();
    set_id(0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // Memory wait of 4 cycles with a branch in the 2nd; flush on the 5th only.
    mem_ready = 1'b0;
    step();
    branch_taken = 1'b1; step();
    branch_taken = 1'b0; step(); step();
    mem_ready = 1'b1; step();
    step();

    // Reset in the middle of a memory wait with a hazard pending.
    set_id(1, 4'd0, 4'd0, 0, 1, 0, 4'd1); step();
    mem_ready = 1'b0;
    set_id(1, 4'd1, 4'd0, 0, 1, 0, 4'd8); step(); step();
    rst = 1'b1; step();
    rst = 1'b0; mem_ready = 1'b1;
    #3;
    chk("post_rst_freeze", 16'(freeze), 16'd0);
    chk("post_rst_stalls", 16'(stall_cycles), 16'd0);
    #1;
    step();
    set_id(0, 0, 0, 0, 0, 0, 0); step();

    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
             4'($urandom_range(0, 3)));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_ready    = ($urandom_range(0, 5) != 0);
      rst          = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; branch_taken = 1'b0; mem_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0); step();

    // Long memory wait drives the stall counter into saturation.
    mem_ready = 1'b0;
    repeat (CNT_MAX + 6) step();
    mem_ready = 1'b1;
    repeat (2) step();
    chk("sat_stalls", 16'(stall_cycles), 16'(CNT_MAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
